// File: rtl/dot_product_pkg.sv
// Shared defaults and width helpers for the streaming dot-product accumulator.
package dot_product_pkg;
  localparam int N_DEF       = 8;
  localparam int MAX_LEN_DEF = 4;

  function automatic int acc_width(input int n, input int len);
    return 2*n + $clog2(len);
  endfunction

  function automatic int cnt_width(input int len);
    return $clog2(len) + 1;
  endfunction
endpackage

// File: rtl/dot_product_acc_if.sv
// Operand stream in, result stream out; slave is the accumulator, master the producer/consumer.
interface dot_product_acc_if import dot_product_pkg::*; #(
  parameter int N     = N_DEF,
  parameter int ACC_W = acc_width(N_DEF, MAX_LEN_DEF),
  parameter int CW    = cnt_width(MAX_LEN_DEF)
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CW-1:0]    out_count;
  logic             out_ovf;

  modport master (output in_valid, in_a, in_b, in_last, out_ready,
                  input  in_ready, out_valid, out_sum, out_count, out_ovf);
  modport slave  (input  in_valid, in_a, in_b, in_last, out_ready,
                  output in_ready, out_valid, out_sum, out_count, out_ovf);
endinterface

// File: rtl/multiplier.sv
// Combinational unsigned array multiplier: p = a * b built from shifted partial products.
module multiplier #(
  parameter int N = 8
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < N; i++)
      if (b[i]) p = p + ((2*N)'(a) << i);
  end
endmodule

// File: rtl/dot_product_acc.sv
// Streaming dot-product: one registered product stage feeding an accumulator that
// emits sum/count/overflow when the element flagged last drains.
module dot_product_acc import dot_product_pkg::*; #(
  parameter int N       = N_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int ACC_W   = acc_width(N, MAX_LEN),
  parameter int CW      = cnt_width(MAX_LEN)
) (
  input logic               clk,
  input logic               rst_n,
  dot_product_acc_if.slave  bus
);
  logic [2*N-1:0]   mul_p;
  logic [2*N-1:0]   prod;
  logic             prod_last;
  logic             prod_valid;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             out_valid;
  logic [ACC_W-1:0] out_sum;
  logic [CW-1:0]    out_count;
  logic             out_ovf;

  logic             acc_take;
  logic             in_fire;
  logic [ACC_W-1:0] acc_sum;
  logic [CW:0]      cnt_p1;
  logic [CW-1:0]    cnt_sat;

  multiplier #(.N(N)) u_mul (.a(bus.in_a), .b(bus.in_b), .p(mul_p));

  // Only a second 'last' stalls: it has nowhere to go while a result waits.
  assign acc_take = prod_valid && !(prod_last && out_valid && !bus.out_ready);
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign acc_sum  = acc + ACC_W'(prod);
  assign cnt_p1   = {1'b0, cnt} + (CW+1)'(1);
  assign cnt_sat  = cnt_p1[CW] ? {CW{1'b1}} : cnt_p1[CW-1:0];

  assign bus.in_ready  = !prod_valid || acc_take;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.out_count = out_count;
  assign bus.out_ovf   = out_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= '0;
      prod_last  <= 1'b0;
      prod_valid <= 1'b0;
    end else if (in_fire) begin
      prod       <= mul_p;
      prod_last  <= bus.in_last;
      prod_valid <= 1'b1;
    end else if (acc_take) begin
      prod_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (acc_take && !prod_last) begin
        acc <= acc_sum;
        cnt <= cnt_sat;
      end
      // A fresh result load wins over the consumer draining the old one.
      if (acc_take && prod_last) begin
        out_sum   <= acc_sum;
        out_count <= cnt_sat;
        out_ovf   <= cnt_p1 > (CW+1)'(MAX_LEN);
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dot_product_acc.sv
// Directed bench for dot_product_acc: table of streamed vectors plus backpressure and reset sequences.
module tb_dot_product_acc;
  import dot_product_pkg::*;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        last;
    logic [17:0] exp_sum;
    logic [2:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [17:0] sum;
    logic [2:0]  cnt;
    logic        ovf;
    int          cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  res_t resq[$];

  dot_product_acc_if bus ();
  dot_product_acc dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.out_valid && bus.out_ready)
      resq.push_back('{sum: bus.out_sum, cnt: bus.out_count, ovf: bus.out_ovf, cyc: cyc});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last, output int acc_cyc);
    bit done = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_last = last;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  vec_t tbl[$];
  int   last_cyc[$];

  initial begin
    int c, r;
    bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_last = 0; bus.out_ready = 1;

    tbl = '{
      '{8'd1,   8'd2,   1'b0, 18'd0,      3'd0, 1'b0},
      '{8'd3,   8'd4,   1'b0, 18'd0,      3'd0, 1'b0},
      '{8'd5,   8'd6,   1'b0, 18'd0,      3'd0, 1'b0},
      '{8'd7,   8'd8,   1'b1, 18'd100,    3'd4, 1'b0},
      '{8'd255, 8'd255, 1'b1, 18'd65025,  3'd1, 1'b0},
      '{8'd255, 8'd255, 1'b0, 18'd0,      3'd0, 1'b0},
      '{8'd255, 8'd255, 1'b0, 18'd0,      3'd0, 1'b0},
      '{8'd255, 8'd255, 1'b0, 18'd0,      3'd0, 1'b0},
      '{8'd255, 8'd255, 1'b1, 18'd260100, 3'd4, 1'b0},
      '{8'd1,   8'd1,   1'b0, 18'd0,      3'd0, 1'b0},
      '{8'd1,   8'd1,   1'b0, 18'd0,      3'd0, 1'b0},
      '{8'd1,   8'd1,   1'b0, 18'd0,      3'd0, 1'b0},
      '{8'd1,   8'd1,   1'b0, 18'd0,      3'd0, 1'b0},
      '{8'd1,   8'd1,   1'b1, 18'd5,      3'd5, 1'b1},
      '{8'd1,   8'd1,   1'b1, 18'd1,      3'd1, 1'b0}
    };

    #12;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_sum",   bus.out_sum,   0);
    check("reset_out_count", bus.out_count, 0);
    check("reset_out_ovf",   bus.out_ovf,   0);
    check("reset_in_ready",  bus.in_ready,  1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Streamed vectors, back-to-back, no backpressure
    foreach (tbl[i]) begin
      send(tbl[i].a, tbl[i].b, tbl[i].last, c);
      if (tbl[i].last) last_cyc.push_back(c);
    end
    repeat (4) @(posedge clk);
    #1;
    r = 0;
    check("table_result_count", resq.size(), last_cyc.size());
    foreach (tbl[i]) if (tbl[i].last) begin
      if (r < resq.size()) begin
        check($sformatf("sum[%0d]", i),     resq[r].sum, tbl[i].exp_sum);
        check($sformatf("count[%0d]", i),   resq[r].cnt, tbl[i].exp_cnt);
        check($sformatf("ovf[%0d]", i),     resq[r].ovf, tbl[i].exp_ovf);
        check($sformatf("latency[%0d]", i), resq[r].cyc, last_cyc[r] + 1);
      end
      r++;
    end

    // Backpressure: second last stalls in the product stage
    resq.delete();
    bus.out_ready = 1'b0;
    send(8'd2, 8'd3, 1'b1, c);
    send(8'd4, 8'd5, 1'b0, c);
    send(8'd1, 8'd1, 1'b1, c);
    @(negedge clk);
    check("bp_in_ready",  bus.in_ready,  0);
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_sum",       bus.out_sum,   6);
    check("bp_count",     bus.out_count, 1);
    repeat (3) @(negedge clk);
    check("bp_hold_sum",      bus.out_sum,  6);
    check("bp_hold_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("bp_result_count", resq.size(), 2);
    if (resq.size() >= 2) begin
      check("bp_first_sum",   resq[0].sum, 6);
      check("bp_first_cnt",   resq[0].cnt, 1);
      check("bp_second_sum",  resq[1].sum, 21);
      check("bp_second_cnt",  resq[1].cnt, 2);
    end

    // Reset mid-vector discards the partial sum
    resq.delete();
    @(posedge clk); #1;
    send(8'd9, 8'd9, 1'b0, c);
    send(8'd9, 8'd9, 1'b0, c);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_sum",   bus.out_sum,   0);
    check("mid_rst_out_count", bus.out_count, 0);
    check("mid_rst_in_ready",  bus.in_ready,  1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'd2, 8'd3, 1'b1, c);
    repeat (3) @(negedge clk);
    check("post_rst_results", resq.size(), 1);
    if (resq.size() >= 1) begin
      check("post_rst_sum",   resq[0].sum, 6);
      check("post_rst_count", resq[0].cnt, 1);
      check("post_rst_ovf",   resq[0].ovf, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dot_product_acc.md
Name: dot_product_acc

Overview:
- Streaming dot-product accumulator directly downstream of the combinational `multiplier`.
- Accepts operand pairs over a valid/ready stream, multiplies each pair in one registered product stage, and accumulates the products until an element flagged `last` arrives.
- Presents the vector sum, the element count and an overflow flag on a valid/ready output.
- Turns the array multiplier into a vector engine.

Parameters:
- N, 8, operand width; passed unchanged to the multiplier.
- MAX_LEN, 4, largest vector length guaranteed not to wrap the accumulator.
- ACC_W, 2*N+$clog2(MAX_LEN), accumulator and sum width (default 18).
- CW, $clog2(MAX_LEN)+1, element-count width (default 3).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept a pair this cycle
- in_a  input  N  operand a
- in_b  input  N  operand b
- in_last  input  1  final element of current vector
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  ACC_W  sum of a*b over the vector
- out_count  output  CW  number of elements in the vector, saturating at 2^CW-1
- out_ovf  output  1  vector had more than MAX_LEN elements

Behaviour:
- Reset (async assert, sync release): prod_valid=0, acc=0, cnt=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0. A partial vector is discarded; the next accepted element starts a new vector.
- Input handshake:
  - Accept when in_valid && in_ready.
  - The pair's product (2N bits, from the `multiplier` instance) and in_last are registered into the product stage with prod_valid=1.
- Accumulate stage:
  - acc_take = prod_valid && !(prod_last && out_valid && !out_ready).
  - in_ready = !prod_valid || acc_take. The input must not depend on in_valid combinationally.
- On acc_take with prod_last=0:
  - acc <= acc + product, zero-extended to ACC_W, wrapping modulo 2^ACC_W.
  - cnt <= cnt+1, saturating at 2^CW-1.
- On acc_take with prod_last=1:
  - out_sum <= acc + product; out_count <= cnt+1 (saturating).
  - out_ovf <= (cnt+1 > MAX_LEN), computed before saturation.
  - out_valid <= 1; acc <= 0; cnt <= 0.
- Output handshake:
  - out_valid clears on out_valid && out_ready unless a new result loads the same cycle; load has priority and out_valid stays 1.
  - out_sum/out_count/out_ovf are held stable while out_valid && !out_ready.
- Latency: a pair with last accepted at edge t gives out_valid=1 after edge t+1. With no backpressure, throughput is 1 element/cycle, including back-to-back vectors.
- Backpressure: accumulation of the next vector continues while a result waits; the pipe stalls only when a second `last` reaches the product stage.
- Single-element vector: out_sum=a*b, out_count=1.
- Zero-length vectors cannot be expressed.
- Consumer contract: in_a/in_b/in_last are don't-care when in_valid=0. In sim the bench must not drop in_valid before acceptance.
- FSM is implicit in prod_valid/out_valid (EMPTY, PROD, HOLD, HOLD+PROD). No explicit state enum is required.

Decomposition:
- Package dot_product_pkg: default N/MAX_LEN, function acc_width(n,len) and cnt_width(len).
- Sub-module: one instance of the existing `multiplier #(N)` (ports a, b, p) for the product. The block contains no inline `*`.

Test Plan:
1. Vector (1,2),(3,4),(5,6),(7,8,last) back-to-back, out_ready=1 -> out_sum=100, out_count=4, out_ovf=0; out_valid one cycle after the last pair's product registers.
2. Single (255,255,last) -> out_sum=65025, out_count=1, out_ovf=0.
3. Four (255,255), last on 4th -> out_sum=260100 (no wrap in 18 bits), out_count=4.
4. out_ready=0; send (2,3,last) then (4,5),(1,1,last):
   - first result 6 held stable;
   - in_ready drops once the second last is in the product stage;
   - raise out_ready -> results 6 (count 1) then 21 (count 2), in order, none lost.
5. Five (1,1), last on 5th -> out_sum=5, out_count=5, out_ovf=1. Then a normal (1,1,last) -> out_ovf=0, confirming the flag is not sticky.
6. Two (9,9) accepted, pulse rst_n low mid-vector -> all outputs 0 immediately; then (2,3,last) -> out_sum=6, out_count=1.
